pc_fetch_ctrl: RTL and testbench

PC register and instruction-fetch controller for the IF stage. Holds `PCF`, which drives the PC adder. Takes back `PCPlus4F` and the branch, jump and exception redirects, and selects the next PC. Issues one blocking fetch at a time on the sram-like instruction port. Presents the fetched word to the IF/ID register, and stalls the pipeline while a fetch is in flight.

---
 rtl/pc_fetch_ctrl_if.sv | 24 ++
 rtl/pc_fetch_ctrl.sv | 150 +++++++++++++++
 tb/tb_pc_fetch_ctrl.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/pc_fetch_ctrl_if.sv
// sram-like instruction port between the IF-stage fetch controller and instruction memory.
interface pc_fetch_ctrl_if;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_addr_ok;
    logic        inst_data_ok;
    logic [31:0] inst_rdata;

    modport master (
        output inst_req,
        output inst_addr,
        input  inst_addr_ok,
        input  inst_data_ok,
        input  inst_rdata
    );

    modport slave (
        input  inst_req,
        input  inst_addr,
        output inst_addr_ok,
        output inst_data_ok,
        output inst_rdata
    );
endinterface

// File: rtl/pc_fetch_ctrl.sv
// IF-stage PC register and blocking instruction-fetch controller (one outstanding request).
module pc_fetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'hBFC0_0000
) (
    input  logic                  clk,
    input  logic                  reset,
    output logic [31:0]           PCF,
    input  logic [31:0]           PCPlus4F,
    input  logic                  StallF,
    input  logic                  ExcFlush,
    input  logic [31:0]           ExcPC,
    input  logic                  BranchTakenD,
    input  logic [31:0]           PCBranchD,
    input  logic                  JumpD,
    input  logic [31:0]           PCJumpD,
    pc_fetch_ctrl_if.master       ibus,
    output logic [31:0]           InstrF,
    output logic                  InstrValidF,
    output logic                  AddrErrF,
    output logic                  FetchBusy
);

    typedef enum logic [1:0] {
        S_REQ,
        S_WAIT,
        S_HOLD
    } state_t;

    state_t      state, state_nx;
    logic        pend_v;
    logic [31:0] pend_pc;

    logic        redir;
    logic [31:0] redir_pc;
    logic        misaligned;

    logic        pc_ld;
    logic [31:0] pc_nx;
    logic        pend_set;
    logic        pend_clr;
    logic        out_ld;
    logic [31:0] instr_nx;
    logic        adderr_nx;

    always_comb begin
        redir    = ExcFlush | BranchTakenD | JumpD;
        redir_pc = PCJumpD;
        if (ExcFlush)
            redir_pc = ExcPC;
        else if (BranchTakenD)
            redir_pc = PCBranchD;
    end

    assign misaligned = |PCF[1:0];

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= S_REQ;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx  = state;
        pc_ld     = 1'b0;
        pc_nx     = PCF;
        pend_set  = 1'b0;
        pend_clr  = 1'b0;
        out_ld    = 1'b0;
        instr_nx  = InstrF;
        adderr_nx = AddrErrF;
        case (state)
            S_REQ: begin
                if (misaligned) begin
                    out_ld    = 1'b1;
                    instr_nx  = '0;
                    adderr_nx = 1'b1;
                    state_nx  = S_HOLD;
                end else if (ibus.inst_addr_ok) begin
                    pend_set = redir;
                    state_nx = S_WAIT;
                end else if (redir) begin
                    pc_ld = 1'b1;
                    pc_nx = redir_pc;
                end
            end
            S_WAIT: begin
                if (ibus.inst_data_ok) begin
                    // A redirect seen during the fetch means the returned word is stale.
                    if (pend_v || redir) begin
                        pc_ld    = 1'b1;
                        pc_nx    = redir ? redir_pc : pend_pc;
                        pend_clr = 1'b1;
                        state_nx = S_REQ;
                    end else begin
                        out_ld    = 1'b1;
                        instr_nx  = ibus.inst_rdata;
                        adderr_nx = 1'b0;
                        state_nx  = S_HOLD;
                    end
                end else begin
                    pend_set = redir;
                end
            end
            S_HOLD: begin
                if (redir) begin
                    pc_ld    = 1'b1;
                    pc_nx    = redir_pc;
                    state_nx = S_REQ;
                end else if (!StallF) begin
                    pc_ld    = 1'b1;
                    pc_nx    = PCPlus4F;
                    state_nx = S_REQ;
                end
            end
            default: state_nx = S_REQ;
        endcase
    end

    always_comb begin
        ibus.inst_req  = (state == S_REQ) && !misaligned && !reset;
        ibus.inst_addr = PCF;
        InstrValidF    = (state == S_HOLD);
        FetchBusy      = (state != S_HOLD);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            PCF      <= RESET_PC;
            pend_v   <= 1'b0;
            pend_pc  <= '0;
            InstrF   <= '0;
            AddrErrF <= 1'b0;
        end else begin
            if (pc_ld)
                PCF <= pc_nx;
            if (pend_set) begin
                pend_v  <= 1'b1;
                pend_pc <= redir_pc;
            end else if (pend_clr) begin
                pend_v <= 1'b0;
            end
            if (out_ld) begin
                InstrF   <= instr_nx;
                AddrErrF <= adderr_nx;
            end
        end
    end

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Scoreboard bench for pc_fetch_ctrl: directed redirect/stall/reset scenarios against a latency-programmable memory.
module tb_pc_fetch_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] PCF;
    logic [31:0] PCPlus4F;
    logic        StallF, ExcFlush, BranchTakenD, JumpD;
    logic [31:0] ExcPC, PCBranchD, PCJumpD;
    logic [31:0] InstrF;
    logic        InstrValidF, AddrErrF, FetchBusy;

    logic        mem_en, stray_dok, mem_pend, mem_dok;
    logic [3:0]  mem_lat, mem_cnt;
    logic [31:0] mem_raddr;

    int unsigned checks = 0;
    int unsigned failures = 0;

    logic [31:0] exp_addr_q[$];
    logic [32:0] exp_instr_q[$];
    logic        prev_valid = 1'b0;

    pc_fetch_ctrl_if ibus ();

    pc_fetch_ctrl #(.RESET_PC(32'hBFC0_0000)) dut (
        .clk          (clk),
        .reset        (reset),
        .PCF          (PCF),
        .PCPlus4F     (PCPlus4F),
        .StallF       (StallF),
        .ExcFlush     (ExcFlush),
        .ExcPC        (ExcPC),
        .BranchTakenD (BranchTakenD),
        .PCBranchD    (PCBranchD),
        .JumpD        (JumpD),
        .PCJumpD      (PCJumpD),
        .ibus         (ibus),
        .InstrF       (InstrF),
        .InstrValidF  (InstrValidF),
        .AddrErrF     (AddrErrF),
        .FetchBusy    (FetchBusy)
    );

    always #5 clk = ~clk;

    assign PCPlus4F          = PCF + 32'd4;
    assign mem_dok           = mem_pend && (mem_cnt == 4'd0);
    assign ibus.inst_addr_ok = ibus.inst_req & mem_en;
    assign ibus.inst_data_ok = mem_dok | stray_dok;
    assign ibus.inst_rdata   = stray_dok ? 32'hDEAD_BEEF :
                               mem_dok   ? (mem_raddr ^ 32'h1234_5678) : 32'hFFFF_FFFF;

    // Memory returns data mem_lat cycles after the address handshake.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_pend  <= 1'b0;
            mem_cnt   <= 4'd0;
            mem_raddr <= 32'd0;
        end else if (mem_pend) begin
            if (mem_cnt != 4'd0)
                mem_cnt <= mem_cnt - 4'd1;
            else
                mem_pend <= 1'b0;
        end else if (ibus.inst_req && ibus.inst_addr_ok) begin
            mem_pend  <= 1'b1;
            mem_cnt   <= mem_lat - 4'd1;
            mem_raddr <= ibus.inst_addr;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(input int budget, input string name);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            cyc(1);
            seen = InstrValidF;
        end
        checks++;
        if (!seen) begin
            failures++;
            $display("FAIL %s: InstrValidF got 0 expected 1 within %0d cycles", name, budget);
        end
    endtask

    // Monitor: every address handshake and every rising InstrValidF is matched against the queues.
    always @(negedge clk) begin
        if (!reset && ibus.inst_req && ibus.inst_addr_ok) begin
            if (exp_addr_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_req: got addr %h expected no request", ibus.inst_addr);
            end else begin
                check("req_addr", ibus.inst_addr, exp_addr_q.pop_front());
            end
        end
        if (InstrValidF && !prev_valid) begin
            if (exp_instr_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_valid: got instr %h expected none", InstrF);
            end else begin
                logic [32:0] e;
                e = exp_instr_q.pop_front();
                check("instr", InstrF, e[31:0]);
                check("adderr", {31'd0, AddrErrF}, {31'd0, e[32]});
            end
        end
        prev_valid = InstrValidF;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        StallF = 1'b1; ExcFlush = 1'b0; BranchTakenD = 1'b0; JumpD = 1'b0;
        ExcPC = 32'd0; PCBranchD = 32'd0; PCJumpD = 32'd0;
        mem_en = 1'b1; mem_lat = 4'd1; stray_dok = 1'b0;
        reset = 1'b1;
        cyc(2);

        check("rst_pcf", PCF, 32'hBFC0_0000);
        check("rst_req", {31'd0, ibus.inst_req}, 32'd0);
        check("rst_valid", {31'd0, InstrValidF}, 32'd0);
        check("rst_busy", {31'd0, FetchBusy}, 32'd1);
        check("rst_instr", InstrF, 32'd0);
        check("rst_adderr", {31'd0, AddrErrF}, 32'd0);

        // Reset release, fastest memory
        exp_addr_q.push_back(32'hBFC0_0000);
        exp_instr_q.push_back({1'b0, 32'hADF4_5678});
        reset = 1'b0;
        #1;
        check("first_req", {31'd0, ibus.inst_req}, 32'd1);
        check("first_addr", ibus.inst_addr, 32'hBFC0_0000);
        cyc(1);
        check("wait_not_valid", {31'd0, InstrValidF}, 32'd0);
        cyc(1);
        check("valid_at_plus2", {31'd0, InstrValidF}, 32'd1);

        // Stall held for three cycles in HOLD
        for (int i = 0; i < 3; i++) begin
            cyc(1);
            check("stall_instr", InstrF, 32'hADF4_5678);
            check("stall_pcf", PCF, 32'hBFC0_0000);
            check("stall_noreq", {31'd0, ibus.inst_req}, 32'd0);
        end
        exp_addr_q.push_back(32'hBFC0_0004);
        exp_instr_q.push_back({1'b0, 32'hADF4_567C});
        StallF = 1'b0;
        cyc(1);
        StallF = 1'b1;
        check("seq_pcf", PCF, 32'hBFC0_0004);
        check("seq_req", {31'd0, ibus.inst_req}, 32'd1);
        wait_valid(10, "seq_valid");

        // Branch during WAIT with slow data: returned word discarded
        mem_lat = 4'd4;
        exp_addr_q.push_back(32'hBFC0_0008);
        StallF = 1'b0;
        cyc(1);
        StallF = 1'b1;
        check("br_req_addr", ibus.inst_addr, 32'hBFC0_0008);
        cyc(1);
        check("br_in_wait", {31'd0, FetchBusy}, 32'd1);
        BranchTakenD = 1'b1;
        PCBranchD = 32'hBFC0_0100;
        cyc(1);
        BranchTakenD = 1'b0;
        mem_lat = 4'd1;
        check("br_pcf_hold", PCF, 32'hBFC0_0008);
        exp_addr_q.push_back(32'hBFC0_0100);
        exp_instr_q.push_back({1'b0, 32'hADF4_5778});
        wait_valid(12, "br_valid");
        check("br_pcf", PCF, 32'hBFC0_0100);

        // Jump and exception together in HOLD: exception wins
        exp_addr_q.push_back(32'hBFC0_0380);
        exp_instr_q.push_back({1'b0, 32'hADF4_55F8});
        JumpD = 1'b1; PCJumpD = 32'hBFC0_0200;
        ExcFlush = 1'b1; ExcPC = 32'hBFC0_0380;
        cyc(1);
        JumpD = 1'b0; ExcFlush = 1'b0;
        check("exc_pcf", PCF, 32'hBFC0_0380);
        check("exc_valid_drop", {31'd0, InstrValidF}, 32'd0);
        wait_valid(10, "exc_valid");

        // Misaligned exception target
        exp_instr_q.push_back({1'b1, 32'h0000_0000});
        ExcFlush = 1'b1; ExcPC = 32'hBFC0_0382;
        cyc(1);
        ExcFlush = 1'b0;
        check("mis_pcf", PCF, 32'hBFC0_0382);
        check("mis_noreq", {31'd0, ibus.inst_req}, 32'd0);
        cyc(1);
        check("mis_valid", {31'd0, InstrValidF}, 32'd1);
        check("mis_adderr", {31'd0, AddrErrF}, 32'd1);
        check("mis_instr", InstrF, 32'd0);
        cyc(1);
        check("mis_hold_adderr", {31'd0, AddrErrF}, 32'd1);
        check("mis_hold_noreq", {31'd0, ibus.inst_req}, 32'd0);

        // Reset asserted mid-fetch, then a stray data_ok in REQ
        mem_lat = 4'd3;
        exp_addr_q.push_back(32'hBFC0_0010);
        BranchTakenD = 1'b1; PCBranchD = 32'hBFC0_0010;
        cyc(1);
        BranchTakenD = 1'b0;
        cyc(1);
        check("rst2_in_wait", {31'd0, FetchBusy & ~InstrValidF}, 32'd1);
        #2 reset = 1'b1;
        #1;
        check("rst2_pcf", PCF, 32'hBFC0_0000);
        check("rst2_req", {31'd0, ibus.inst_req}, 32'd0);
        check("rst2_valid", {31'd0, InstrValidF}, 32'd0);
        check("rst2_busy", {31'd0, FetchBusy}, 32'd1);
        check("rst2_instr", InstrF, 32'd0);
        check("rst2_adderr", {31'd0, AddrErrF}, 32'd0);
        cyc(2);
        mem_en = 1'b0;
        stray_dok = 1'b1;
        reset = 1'b0;
        cyc(1);
        stray_dok = 1'b0;
        check("stray_req", {31'd0, ibus.inst_req}, 32'd1);
        check("stray_valid", {31'd0, InstrValidF}, 32'd0);
        check("stray_pcf", PCF, 32'hBFC0_0000);
        mem_lat = 4'd1;
        exp_addr_q.push_back(32'hBFC0_0000);
        exp_instr_q.push_back({1'b0, 32'hADF4_5678});
        mem_en = 1'b1;
        wait_valid(10, "post_rst_valid");
        cyc(1);

        check("addr_q_empty", exp_addr_q.size(), 32'd0);
        check("instr_q_empty", exp_instr_q.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
